life_gen_updater: RTL and testbench

Consumer end of the board traversal interface. Drives the traverser's `enable` to step through the board one cell at a time, and latches each `addrC`/`addrR` it presents. For each cell it reads the 3x3 neighbourhood from the current-generation board memory, applies the Life rule, and writes the next state into the next-generation board memory. It pulses `gen_done` once the final cell, flagged by the traverser's `finish`, has been written.

---
 rtl/life_gen_updater.sv | 210 +++++++++++++++++++++
 tb/tb_life_gen_updater.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_gen_updater.sv
// Game-of-Life generation updater: walks the board via the traverser, reads each 3x3
// neighbourhood and writes the next state. Define LIFE_WRAP_EN for a toroidal board.
module life_gen_updater #(
    parameter int MAP_WIDTH  = 8,
    parameter int MAP_HEIGHT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] addrC,
    input  logic [7:0] addrR,
    input  logic       finish,
    output logic       enable,
    output logic       rd_en,
    output logic [7:0] rd_addrC,
    output logic [7:0] rd_addrR,
    input  logic       rd_data,
    output logic       wr_en,
    output logic [7:0] wr_addrC,
    output logic [7:0] wr_addrR,
    output logic       wr_data,
    output logic       busy,
    output logic       gen_done
);

    typedef enum logic [2:0] {IDLE, LATCH, READ, DRAIN, WRITE, STEP, DONE} state_t;

    localparam logic [7:0] COL_MAX = 8'(MAP_WIDTH - 1);
    localparam logic [7:0] ROW_MAX = 8'(MAP_HEIGHT - 1);

    state_t     state_q, state_d;
    logic [3:0] k_q, k_d;
    logic [7:0] cc_q, cc_d, cr_q, cr_d;
    logic       last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic       self_q, self_d;
    logic       pend_q, pend_self_q;

    logic       enable_q, rd_en_q, wr_en_q, wr_data_q, busy_q, gen_done_q;
    logic [7:0] rd_addrC_q, rd_addrR_q, wr_addrC_q, wr_addrR_q;

    logic       rd_en_d, wr_data_d;
    logic [1:0] dr_sel, dc_sel;
    logic [7:0] nc, nr;
    logic       col_ok, row_ok;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cc_d    = cc_q;
        cr_d    = cr_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        self_d  = self_q;
        // Read data lags its strobe by one cycle, so accumulation trails the READ index.
        if (pend_q) begin
            if (pend_self_q) self_d = rd_data;
            else             cnt_d  = cnt_q + {3'b000, rd_data};
        end
        case (state_q)
            IDLE:  if (start) state_d = LATCH;
            LATCH: begin
                cc_d    = addrC;
                cr_d    = addrR;
                last_d  = finish;
                cnt_d   = '0;
                self_d  = 1'b0;
                k_d     = '0;
                state_d = READ;
            end
            READ: begin
                if (k_q == 4'd8) state_d = DRAIN;
                else             k_d     = k_q + 4'd1;
            end
            DRAIN: state_d = WRITE;
            WRITE: state_d = last_q ? DONE : STEP;
            STEP:  state_d = LATCH;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (k_d)
            4'd0, 4'd1, 4'd2: dr_sel = 2'd0;
            4'd3, 4'd4, 4'd5: dr_sel = 2'd1;
            default:          dr_sel = 2'd2;
        endcase
        case (k_d)
            4'd0, 4'd3, 4'd6: dc_sel = 2'd0;
            4'd1, 4'd4, 4'd7: dc_sel = 2'd1;
            default:          dc_sel = 2'd2;
        endcase
    end

    // Neighbour coordinates for the read issued next cycle; border handling is build-selected.
    always_comb begin
        nc     = cc_d;
        col_ok = 1'b1;
        case (dc_sel)
            2'd0: begin
                if (cc_d == '0) begin
`ifdef LIFE_WRAP_EN
                    nc = COL_MAX;
`else
                    nc     = '0;
                    col_ok = 1'b0;
`endif
                end else nc = cc_d - 8'd1;
            end
            2'd2: begin
                if (cc_d == COL_MAX) begin
                    nc = '0;
`ifndef LIFE_WRAP_EN
                    col_ok = 1'b0;
`endif
                end else nc = cc_d + 8'd1;
            end
            default: nc = cc_d;
        endcase
    end

    always_comb begin
        nr     = cr_d;
        row_ok = 1'b1;
        case (dr_sel)
            2'd0: begin
                if (cr_d == '0) begin
`ifdef LIFE_WRAP_EN
                    nr = ROW_MAX;
`else
                    nr     = '0;
                    row_ok = 1'b0;
`endif
                end else nr = cr_d - 8'd1;
            end
            2'd2: begin
                if (cr_d == ROW_MAX) begin
                    nr = '0;
`ifndef LIFE_WRAP_EN
                    row_ok = 1'b0;
`endif
                end else nr = cr_d + 8'd1;
            end
            default: nr = cr_d;
        endcase
    end

    always_comb begin
        rd_en_d   = (state_d == READ) & col_ok & row_ok;
        wr_data_d = (state_d == WRITE) &
                    ((cnt_d == 4'd3) | (self_d & (cnt_d == 4'd2)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            cc_q        <= '0;
            cr_q        <= '0;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            self_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_self_q <= 1'b0;
            enable_q    <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addrC_q  <= '0;
            rd_addrR_q  <= '0;
            wr_en_q     <= 1'b0;
            wr_addrC_q  <= '0;
            wr_addrR_q  <= '0;
            wr_data_q   <= 1'b0;
            busy_q      <= 1'b0;
            gen_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cc_q        <= cc_d;
            cr_q        <= cr_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            self_q      <= self_d;
            pend_q      <= rd_en_q;
            pend_self_q <= rd_en_q & (k_q == 4'd4);
            enable_q    <= (state_d == STEP);
            rd_en_q     <= rd_en_d;
            rd_addrC_q  <= rd_en_d ? nc : '0;
            rd_addrR_q  <= rd_en_d ? nr : '0;
            wr_en_q     <= (state_d == WRITE);
            wr_addrC_q  <= (state_d == WRITE) ? cc_d : '0;
            wr_addrR_q  <= (state_d == WRITE) ? cr_d : '0;
            wr_data_q   <= wr_data_d;
            busy_q      <= (state_d != IDLE);
            gen_done_q  <= (state_d == DONE);
        end
    end

    assign enable   = enable_q;
    assign rd_en    = rd_en_q;
    assign rd_addrC = rd_addrC_q;
    assign rd_addrR = rd_addrR_q;
    assign wr_en    = wr_en_q;
    assign wr_addrC = wr_addrC_q;
    assign wr_addrR = wr_addrR_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign gen_done = gen_done_q;

endmodule

// File: tb/tb_life_gen_updater.sv
// Bench for life_gen_updater: traverser and board-memory models plus a write scoreboard.
module tb_life_gen_updater;

    localparam int W = 8;
    localparam int H = 8;
    localparam int N = W * H;
`ifdef LIFE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] addrC, addrR;
    logic       finish;
    logic       enable, rd_en, wr_en, wr_data, busy, gen_done;
    logic [7:0] rd_addrC, rd_addrR, wr_addrC, wr_addrR;
    logic       rd_data = 1'b0;

    int vectors    = 0;
    int miscompares = 0;

    bit cur [0:H-1][0:W-1];
    bit nxt [0:H-1][0:W-1];

    typedef struct {
        logic [7:0] c;
        logic [7:0] r;
        logic       d;
    } wr_t;
    wr_t exp_q[$];

    life_gen_updater #(.MAP_WIDTH(W), .MAP_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .start(start),
        .addrC(addrC), .addrR(addrR), .finish(finish),
        .enable(enable), .rd_en(rd_en), .rd_addrC(rd_addrC), .rd_addrR(rd_addrR),
        .rd_data(rd_data), .wr_en(wr_en), .wr_addrC(wr_addrC), .wr_addrR(wr_addrR),
        .wr_data(wr_data), .busy(busy), .gen_done(gen_done)
    );

    always #5 clk = ~clk;

    // Traverser: steps on enable, self-clears to (0,0) the cycle after finish.
    assign finish = (addrC == 8'(W - 1)) && (addrR == 8'(H - 1));
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            addrC <= '0;
            addrR <= '0;
        end else if (finish) begin
            addrC <= '0;
            addrR <= '0;
        end else if (enable) begin
            if (addrC == 8'(W - 1)) begin
                addrC <= '0;
                addrR <= addrR + 8'd1;
            end else addrC <= addrC + 8'd1;
        end
    end

    // Board memories; unread cycles return noise so ungated data would be caught.
    always @(posedge clk) begin
        if (rd_en && rd_addrC < 8'(W) && rd_addrR < 8'(H))
            rd_data <= cur[rd_addrR][rd_addrC];
        else
            rd_data <= 1'($urandom_range(0, 1));
        if (wr_en && wr_addrC < 8'(W) && wr_addrR < 8'(H))
            nxt[wr_addrR][wr_addrC] <= wr_data;
    end

    function automatic bit life_next(int c, int r);
        int n = 0;
        int x, y;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                x = c + dc;
                y = r + dr;
                if (WRAP) begin
                    x = (x + W) % W;
                    y = (y + H) % H;
                end
                if (!(dr == 0 && dc == 0) && x >= 0 && x < W && y >= 0 && y < H)
                    n += int'(cur[y][x]);
            end
        end
        return (n == 3) || (cur[r][c] && n == 2);
    endfunction

    function automatic int slots_in_range(int c, int r);
        int n = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (WRAP || (c + dc >= 0 && c + dc < W && r + dr >= 0 && r + dr < H))
                    n++;
        return n;
    endfunction

    task automatic clear_board();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) cur[r][c] = 1'b0;
    endtask

    task automatic random_board();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) cur[r][c] = 1'($urandom_range(0, 1));
    endtask

    function automatic int live_next();
        int n = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) n += int'(nxt[r][c]);
        return n;
    endfunction

    // One generation from a start at cycle 0; start optionally re-pulsed at cycle repulse.
    task automatic run_gen(input int repulse, output int reads_last);
        int  exp_reads = 0;
        int  reads = 0;
        int  enables = 0;
        int  dones = 0;
        int  excl;
        bit  exp_w, exp_en;
        wr_t e;
        reads_last = 0;
        exp_q.delete();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                exp_q.push_back('{c: 8'(c), r: 8'(r), d: life_next(c, r)});
                exp_reads += slots_in_range(c, r);
                nxt[r][c] = 1'b1;
            end
        @(posedge clk); #1;
        for (int cyc = 0; cyc <= 13 * N + 3; cyc++) begin
            start = (cyc == 0) || (cyc == repulse);
            @(negedge clk);
            vectors++;
            if (busy !== (cyc >= 1 && cyc <= 13 * N)) begin
                miscompares++;
                $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, (cyc >= 1 && cyc <= 13 * N));
            end
            excl = int'(rd_en) + int'(wr_en) + int'(enable) + int'(gen_done);
            vectors++;
            if (excl > 1) begin
                miscompares++;
                $display("FAIL exclusive cyc=%0d got=%0d strobes want<=1", cyc, excl);
            end
            exp_w = (cyc >= 12) && (cyc < 13 * N) && ((cyc - 12) % 13 == 0);
            vectors++;
            if (wr_en !== exp_w) begin
                miscompares++;
                $display("FAIL wr_en cyc=%0d got=%b want=%b", cyc, wr_en, exp_w);
            end
            if (wr_en === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL write_extra cyc=%0d got=(%0d,%0d) want=none", cyc, wr_addrC, wr_addrR);
                end else begin
                    e = exp_q.pop_front();
                    if (wr_addrC !== e.c || wr_addrR !== e.r || wr_data !== e.d) begin
                        miscompares++;
                        $display("FAIL write cyc=%0d got=(%0d,%0d)=%b want=(%0d,%0d)=%b",
                                 cyc, wr_addrC, wr_addrR, wr_data, e.c, e.r, e.d);
                    end
                end
            end
            exp_en = (cyc >= 13) && (cyc < 13 * N) && ((cyc - 13) % 13 == 0);
            vectors++;
            if (enable !== exp_en) begin
                miscompares++;
                $display("FAIL enable cyc=%0d got=%b want=%b", cyc, enable, exp_en);
            end
            vectors++;
            if (gen_done !== (cyc == 13 * N)) begin
                miscompares++;
                $display("FAIL gen_done cyc=%0d got=%b want=%b", cyc, gen_done, (cyc == 13 * N));
            end
            if (enable === 1'b1) enables++;
            if (gen_done === 1'b1) dones++;
            if (rd_en === 1'b1) begin
                reads++;
                if (cyc >= 13 * (N - 1) + 2 && cyc <= 13 * (N - 1) + 10) reads_last++;
                vectors++;
                if (rd_addrC >= 8'(W) || rd_addrR >= 8'(H)) begin
                    miscompares++;
                    $display("FAIL rd_addr cyc=%0d got=(%0d,%0d) want in board", cyc, rd_addrC, rd_addrR);
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        vectors++;
        if (enables != N - 1) begin
            miscompares++;
            $display("FAIL enable_count got=%0d want=%0d", enables, N - 1);
        end
        vectors++;
        if (dones != 1) begin
            miscompares++;
            $display("FAIL gen_done_count got=%0d want=1", dones);
        end
        vectors++;
        if (reads != exp_reads) begin
            miscompares++;
            $display("FAIL read_count got=%0d want=%0d", reads, exp_reads);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL writes_missing got=%0d left want=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({enable, rd_en, rd_addrC, rd_addrR, wr_en, wr_addrC, wr_addrR, wr_data, busy, gen_done} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%b want=0", {enable, rd_en, wr_en, wr_data, busy, gen_done});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_empty();
        int rl;
        clear_board();
        run_gen(-1, rl);
        vectors++;
        if (live_next() != 0) begin
            miscompares++;
            $display("FAIL empty_live got=%0d want=0", live_next());
        end
    endtask

    task automatic test_blinker();
        int rl;
        clear_board();
        cur[2][3] = 1'b1;
        cur[3][3] = 1'b1;
        cur[4][3] = 1'b1;
        run_gen(-1, rl);
        vectors++;
        if (live_next() != 3 || !nxt[3][2] || !nxt[3][3] || !nxt[3][4]) begin
            miscompares++;
            $display("FAIL blinker got=%0d live row3=%b%b%b want=3 live row3=111",
                     live_next(), nxt[3][2], nxt[3][3], nxt[3][4]);
        end
    endtask

    task automatic test_glider_corner();
        int rl;
        clear_board();
        cur[5][6] = 1'b1;
        cur[6][7] = 1'b1;
        cur[7][5] = 1'b1;
        cur[7][6] = 1'b1;
        cur[7][7] = 1'b1;
        run_gen(-1, rl);
        vectors++;
        if (rl != (WRAP ? 9 : 4)) begin
            miscompares++;
            $display("FAIL corner_reads got=%0d want=%0d", rl, (WRAP ? 9 : 4));
        end
        // Cell (6,0) sees three live cells in row 7 only across the wrap.
        vectors++;
        if (nxt[0][6] !== WRAP) begin
            miscompares++;
            $display("FAIL corner_birth got=%b want=%b", nxt[0][6], WRAP);
        end
    endtask

    task automatic test_full();
        int rl;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) cur[r][c] = 1'b1;
        run_gen(-1, rl);
        vectors++;
        if (live_next() != (WRAP ? 0 : 4)) begin
            miscompares++;
            $display("FAIL full_live got=%0d want=%0d", live_next(), (WRAP ? 0 : 4));
        end
    endtask

    task automatic test_restart_ignored();
        int rl;
        random_board();
        run_gen(100, rl);
    endtask

    task automatic test_reset_mid();
        int rl;
        int dones = 0;
        random_board();
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            start = (cyc == 0);
            @(negedge clk);
            if (gen_done === 1'b1) dones++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        rst = 1'b1;
        #1;
        vectors++;
        if ({enable, rd_en, rd_addrC, rd_addrR, wr_en, wr_addrC, wr_addrR, wr_data, busy, gen_done} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs got=%b want=0", {enable, rd_en, wr_en, wr_data, busy, gen_done});
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL midreset_done got=%0d want=0", dones);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        run_gen(-1, rl);
    endtask

    initial begin
        test_reset();
        test_empty();
        test_blinker();
        test_glider_corner();
        test_full();
        test_restart_ignored();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
